// File: rtl/sdram_arbiter.sv
// Command scheduler sharing the SDRAM cmd/addr/bank pins between the init,
// refresh, write and read engines, with refresh priority and a grant watchdog.
module sdram_arbiter #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flag_init_end,
  input  logic [3:0]       init_cmd,
  input  logic [11:0]      init_addr,
  input  logic             ref_req,
  input  logic             flag_ref_end,
  input  logic [3:0]       ref_cmd,
  input  logic [11:0]      ref_addr,
  input  logic             wr_req,
  input  logic             flag_wr_end,
  input  logic [3:0]       wr_cmd,
  input  logic [11:0]      wr_addr,
  input  logic [1:0]       wr_bank,
  input  logic             rd_req,
  input  logic             flag_rd_end,
  input  logic [3:0]       rd_cmd,
  input  logic [11:0]      rd_addr,
  input  logic [1:0]       rd_bank,
  output logic             ref_en,
  output logic             wr_en,
  output logic             rd_en,
  output logic [3:0]       sd_cmd,
  output logic [11:0]      sd_addr,
  output logic [1:0]       sd_bank,
  output logic             wr_dq_oe,
  output logic [4:0]       state_o,
  output logic             timeout_err
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  logic             ref_en_q, wr_en_q, rd_en_q;
  logic             last_wr_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             end_hit;
  logic             pick_wr;

  // Only the granted engine's end flag may close the grant.
  always_comb begin
    end_hit = ((state_q == AREF)  && flag_ref_end) ||
              ((state_q == WRITE) && flag_wr_end)  ||
              ((state_q == READ)  && flag_rd_end);
    pick_wr = wr_req && (!rd_req || !last_wr_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      ref_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      case (state_q)
        IDLE: if (flag_init_end) state_q <= ARBIT;
        ARBIT: begin
          cnt_q <= '0;
          if (ref_req) begin
            state_q  <= AREF;
            ref_en_q <= 1'b1;
          end else if (wr_req || rd_req) begin
            if (pick_wr) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              last_wr_q <= 1'b1;
            end else begin
              state_q   <= READ;
              rd_en_q   <= 1'b1;
              last_wr_q <= 1'b0;
            end
          end
        end
        AREF, WRITE, READ: begin
          // An end flag arriving on the timeout cycle is a clean finish.
          if (end_hit) begin
            state_q <= ARBIT;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ARBIT;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sd_cmd  = CMD_NOP;
    sd_addr = '0;
    sd_bank = '0;
    case (state_q)
      IDLE: begin
        sd_cmd  = init_cmd;
        sd_addr = init_addr;
      end
      AREF: begin
        sd_cmd  = ref_cmd;
        sd_addr = ref_addr;
      end
      WRITE: begin
        sd_cmd  = wr_cmd;
        sd_addr = wr_addr;
        sd_bank = wr_bank;
      end
      READ: begin
        sd_cmd  = rd_cmd;
        sd_addr = rd_addr;
        sd_bank = rd_bank;
      end
      default: ;
    endcase
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign wr_dq_oe    = (state_q == WRITE);
  assign state_o     = state_q;
  assign timeout_err = err_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Standalone command scheduler that shares the SDRAM command, address and bank pins between the init, auto-refresh, write and read engines.
- Waits for init completion, then grants one engine at a time.
- Refresh always has priority; write and read alternate under contention.
- Issues one-cycle enable pulses and muxes the granted engine's command, address and bank onto the pins.
- A watchdog recovers from an engine that never signals end.

Parameters:
TIMEOUT_CYC, 1023, max cycles a grant may last before forced release (>=2)
CNT_W, 10, width of watchdog counter; must hold TIMEOUT_CYC

Ports:
CLK  input  1  system clock, all logic on rising edge
RSTn  input  1  asynchronous active-low reset
flag_init_end  input  1  init sequence complete (level)
init_cmd  input  4  {cs_n,ras_n,cas_n,we_n} from init engine
init_addr  input  12  address from init engine
ref_req  input  1  refresh request (level)
flag_ref_end  input  1  refresh done, 1-cycle pulse
ref_cmd  input  4  refresh engine command
ref_addr  input  12  refresh engine address
wr_req  input  1  write request (level)
flag_wr_end  input  1  write burst done, 1-cycle pulse
wr_cmd  input  4  write engine command
wr_addr  input  12  write engine address
wr_bank  input  2  write engine bank
rd_req  input  1  read request (level)
flag_rd_end  input  1  read burst done, 1-cycle pulse
rd_cmd  input  4  read engine command
rd_addr  input  12  read engine address
rd_bank  input  2  read engine bank
ref_en  output  1  refresh grant pulse
wr_en  output  1  write grant pulse
rd_en  output  1  read grant pulse
sd_cmd  output  4  muxed command to pins
sd_addr  output  12  muxed address
sd_bank  output  2  muxed bank
wr_dq_oe  output  1  DQ output enable, high only in WRITE
state_o  output  5  one-hot state for debug
timeout_err  output  1  sticky watchdog flag

Behaviour:
- State encoding is one-hot: IDLE=00001, ARBIT=00010, AREF=00100, WRITE=01000, READ=10000. Any other value goes to IDLE.
- Reset values:
  - state=IDLE; ref_en, wr_en, rd_en=0; timeout_err=0; watchdog count=0; last_grant=READ, so write wins the first contention.
  - sd_cmd/sd_addr follow init_cmd/init_addr because state is IDLE.
  - sd_bank=0, wr_dq_oe=0.
- IDLE -> ARBIT on the first cycle flag_init_end=1. flag_init_end is ignored afterwards.
- ARBIT samples requests for one cycle only. Priority order:
  - ref_req -> AREF.
  - Else if wr_req and rd_req both high -> grant the one opposite last_grant.
  - Else wr_req -> WRITE.
  - Else rd_req -> READ.
  - Else stay in ARBIT.
- Grant pulse: the matching *_en is registered on the transition edge. It is high for exactly the first cycle of the grant state, then 0. last_grant updates on WRITE/READ entry only; AREF does not change it.
- Grant states (AREF, WRITE, READ) return to ARBIT on the cycle after the matching end flag. End flags from non-granted engines are ignored.
- At least one ARBIT cycle separates consecutive grants. That cycle drives NOP (4'b0111) with address 0 and bank 0.
- Output mux (combinational from state):
  - IDLE: init_cmd/init_addr, bank 0.
  - AREF: ref_cmd/ref_addr, bank 0.
  - WRITE: wr_cmd/wr_addr/wr_bank.
  - READ: rd_cmd/rd_addr/rd_bank.
  - ARBIT: NOP, address 0, bank 0.
- wr_dq_oe = (state==WRITE).
- Watchdog:
  - Counter clears on grant entry and increments each grant-state cycle.
  - If it reaches TIMEOUT_CYC without an end flag, the block returns to ARBIT and sets timeout_err=1. timeout_err stays set until reset.
  - If the end flag and the timeout occur in the same cycle, the end flag wins and timeout_err is not set.
- Async reset mid-grant: immediate return to IDLE, all enables 0. Init must complete again before any grant.

Test Plan:
1. Reset, then flag_init_end at cycle 20, no requests -> state_o 00001 until 21, then 00010; sd_cmd=0111.
2. In ARBIT, raise ref_req, wr_req and rd_req together -> ref_en pulses 1 cycle, state AREF. After flag_ref_end -> one ARBIT cycle, then wr_en pulses (state WRITE). After flag_wr_end -> rd_en pulses (state READ).
3. Hold wr_req and rd_req high continuously through 4 grants -> order W,R,W,R. Each grant has exactly one en pulse, with a 1-cycle NOP gap between grants.
4. WRITE granted, wr_cmd=4'b0100, wr_addr=12'h0A5, wr_bank=2'b10 -> pins carry 0100/0A5/10 and wr_dq_oe=1. In READ, wr_dq_oe=0 and pins carry rd_* values.
5. TIMEOUT_CYC=8, grant READ, never pulse flag_rd_end -> after 8 READ cycles state returns to ARBIT and timeout_err=1 sticky. Repeat with flag_rd_end on cycle 8 -> timeout_err stays 0.
6. Assert RSTn low mid-WRITE -> state IDLE immediately, enables 0, timeout_err 0. No grant occurs until flag_init_end again.
